// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings and constants for the RV32M iterative multiply/divide unit.
package riscv_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int MULDIV_ITER    = 32;
    localparam int MULDIV_LATENCY = 34;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } muldiv_state_t;

    // funct3 bit 2 separates the divide family from the multiply family.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/riscv_muldiv_if.sv
// Start/busy/done request bus between the execute-stage control and the mul/div unit.
interface riscv_muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [2:0]      MulDivOp;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;
    logic            Zero;

    modport master (
        output start, MulDivOp, SrcA, SrcB,
        input  busy, done, Result, Zero
    );

    modport slave (
        input  start, MulDivOp, SrcA, SrcB,
        output busy, done, Result, Zero
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M unit: 32-step shift-add multiply / restoring divide on magnitudes,
// with sign fix-up and RISC-V special cases applied in a single finishing cycle.
module riscv_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    riscv_muldiv_if.slave mdu
);

    localparam int              CNT_W    = $clog2(MULDIV_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITER - 1);
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v,
                                                       input logic neg);
        return neg ? (~v + (2*XLEN)'(1)) : v;
    endfunction

    muldiv_state_t     r_state;
    muldiv_state_t     w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [2:0]        r_op;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_b_zero;
    logic              r_ovf;
    logic [XLEN-1:0]   r_src_a;
    logic [XLEN-1:0]   r_work;
    logic [2*XLEN-1:0] r_acc;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;

    logic              w_sign_a_in;
    logic              w_sign_b_in;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_sub;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (mdu.start) w_state_nxt = ST_CALC;
            ST_CALC:   if (r_count == CNT_LAST) w_state_nxt = ST_FINISH;
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_sign_a_in = op_a_signed(mdu.MulDivOp) & mdu.SrcA[XLEN-1];
    assign w_sign_b_in = op_b_signed(mdu.MulDivOp) & mdu.SrcB[XLEN-1];
    assign w_abs_a     = cond_neg(mdu.SrcA, w_sign_a_in);
    assign w_abs_b     = cond_neg(mdu.SrcB, w_sign_b_in);

    // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_work} : '0);

    // Divide: r_acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge      = (w_rem_sh >= {1'b0, r_work});
    assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_work;
    assign w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];

    assign w_prod = cond_neg_wide(r_acc, r_sign_a ^ r_sign_b);
    assign w_quot = cond_neg(r_acc[XLEN-1:0], r_sign_a ^ r_sign_b);
    assign w_rem  = cond_neg(r_acc[2*XLEN-1:XLEN], r_sign_a);

    always_comb begin
        w_res = '0;
        case (r_op)
            OP_MUL:    w_res = w_prod[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  w_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV:    w_res = r_b_zero ? ALL_ONES : (r_ovf ? MOST_NEG : w_quot);
            OP_DIVU:   w_res = r_b_zero ? ALL_ONES : w_quot;
            OP_REM:    w_res = r_b_zero ? r_src_a : (r_ovf ? '0 : w_rem);
            OP_REMU:   w_res = r_b_zero ? r_src_a : w_rem;
            default:   w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_op     <= OP_MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_ovf    <= 1'b0;
            r_src_a  <= '0;
            r_work   <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mdu.start) begin
                        r_count  <= '0;
                        r_op     <= mdu.MulDivOp;
                        r_sign_a <= w_sign_a_in;
                        r_sign_b <= w_sign_b_in;
                        r_b_zero <= (mdu.SrcB == '0);
                        r_ovf    <= (mdu.SrcA == MOST_NEG) && (mdu.SrcB == ALL_ONES);
                        r_src_a  <= mdu.SrcA;
                        if (op_is_div(mdu.MulDivOp)) begin
                            r_acc  <= {{XLEN{1'b0}}, w_abs_a};
                            r_work <= w_abs_b;
                        end else begin
                            r_acc  <= {{XLEN{1'b0}}, w_abs_b};
                            r_work <= w_abs_a;
                        end
                    end
                end
                ST_CALC: begin
                    r_count <= r_count + 1'b1;
                    if (op_is_div(r_op)) begin
                        r_acc <= {w_rem_nxt, r_acc[XLEN-2:0], w_ge};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                    end
                end
                ST_FINISH: begin
                    r_result <= w_res;
                    r_zero   <= (w_res == '0);
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mdu.busy   = (r_state != ST_IDLE);
    assign mdu.done   = r_done;
    assign mdu.Result = r_result;
    assign mdu.Zero   = r_zero;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Table-driven bench with a result scoreboard plus hand-written handshake/reset sequences.
module tb_riscv_muldiv_unit;
    import riscv_muldiv_pkg::*;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
    } sb_item_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sb_item_t sb_q[$];
    sb_item_t mon_item;

    riscv_muldiv_if #(.XLEN(32)) mdu ();

    riscv_muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (mdu.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%h required=no_done", mdu.Result);
            end else begin
                mon_item = sb_q.pop_front();
                check({mon_item.name, "_result"}, mdu.Result, mon_item.res);
                check({mon_item.name, "_zero"}, {31'd0, mdu.Zero}, {31'd0, mon_item.res == 32'd0});
            end
        end
    end

    // Drive a request so that the next rising edge accepts it; returns #1 after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu.start    = 1'b1;
        mdu.MulDivOp = op;
        mdu.SrcA     = a;
        mdu.SrcB     = b;
        @(posedge clk);
        #1;
        mdu.start = 1'b0;
    endtask

    // Counts edges after the start edge until done, and cycles with busy high.
    task automatic wait_done(output int edges, output int busy_hi, output bit seen);
        edges   = 0;
        busy_hi = 0;
        seen    = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (mdu.busy === 1'b1) busy_hi++;
            if (mdu.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        int edges;
        int busy_hi;
        bit seen;
        sb_item_t it;
        it.name = name;
        it.res  = res;
        sb_q.push_back(it);
        issue(op, a, b);
        wait_done(edges, busy_hi, seen);
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_latency"}, edges, MULDIV_LATENCY - 1);
        check({name, "_busy_cycles"}, busy_hi, MULDIV_LATENCY - 1);
    endtask

    vec_t vecs[];

    initial begin
        int  edges;
        int  busy_hi;
        bit  seen;
        sb_item_t it;

        checks = 0;
        errors = 0;
        mdu.start    = 1'b0;
        mdu.MulDivOp = 3'b000;
        mdu.SrcA     = 32'd0;
        mdu.SrcB     = 32'd0;

        vecs = new[18];
        vecs[0]  = '{"mul_7x6",        OP_MUL,    32'd7,        32'd6,        32'd42};
        vecs[1]  = '{"mulh_min_min",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{"mulhu_max_max",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{"mulhsu_m1_max",  OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4]  = '{"div_m7_2",       OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{"rem_m7_2",       OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{"div_overflow",   OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[7]  = '{"rem_overflow",   OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[8]  = '{"divu_5_0",       OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{"remu_5_0",       OP_REMU,   32'd5,        32'd0,        32'd5};
        vecs[10] = '{"div_m1_0",       OP_DIV,    32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF};
        vecs[11] = '{"mul_m1x5",       OP_MUL,    32'hFFFFFFFF, 32'd5,        32'hFFFFFFFB};
        vecs[12] = '{"divu_100_7",     OP_DIVU,   32'd100,      32'd7,        32'd14};
        vecs[13] = '{"remu_100_7",     OP_REMU,   32'd100,      32'd7,        32'd2};
        vecs[14] = '{"mulh_m2x3",      OP_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
        vecs[15] = '{"rem_7_m2",       OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1};
        vecs[16] = '{"div_7_m2",       OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
        vecs[17] = '{"mulhu_min_4",    OP_MULHU,  32'h80000000, 32'd4,        32'd2};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, mdu.busy}, 32'd0);
        check("reset_done",   {31'd0, mdu.done}, 32'd0);
        check("reset_result", mdu.Result,        32'd0);
        check("reset_zero",   {31'd0, mdu.Zero}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Consecutive vectors start in each other's done cycle, so all run back-to-back.
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
        end
        @(posedge clk);
        #1;
        check("done_single_pulse", {31'd0, mdu.done}, 32'd0);
        check("result_held", mdu.Result, 32'd2);

        // A second start at cycle 10 of a running op must be ignored.
        it.name = "ignored_start";
        it.res  = 32'h00012340;
        sb_q.push_back(it);
        issue(OP_MUL, 32'h1234, 32'h10);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        issue(OP_DIVU, 32'd9, 32'd3);
        wait_done(edges, busy_hi, seen);
        check("ignored_start_done_seen", {31'd0, seen}, 32'd1);
        check("ignored_start_latency", edges + 10, MULDIV_LATENCY - 1);
        repeat (40) @(posedge clk);
        #1;
        check("ignored_start_no_extra_done", {31'd0, mdu.busy}, 32'd0);

        // Reset at cycle 15 of a DIV aborts it without a done pulse.
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_busy", {31'd0, mdu.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy",   {31'd0, mdu.busy}, 32'd0);
        check("abort_done",   {31'd0, mdu.done}, 32'd0);
        check("abort_result", mdu.Result,        32'd0);
        check("abort_zero",   {31'd0, mdu.Zero}, 32'd1);
        wait_done(edges, busy_hi, seen);
        check("abort_no_done", {31'd0, seen}, 32'd0);

        run_op("mul_3x3_after_reset", OP_MUL, 32'd3, 32'd3, 32'd9);

        @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
- Iterative multi-cycle execution unit for the RV32M instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage and takes the same SrcA/SrcB operands.
- Uses a start/busy/done handshake, so the control unit stalls PC and register-file writeback until done.
- Produces a 32-bit result and a Zero flag with the same meaning as the ALU's Zero flag.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- MulDivOp  input  3  operation, funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  32  multiplicand / dividend.
- SrcB  input  32  multiplier / divisor.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; Result is valid from this cycle on.
- Result  output  32  result; held until the next done.
- Zero  output  1  (Result == 0), registered together with Result.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset=1 at a rising edge: state=IDLE; busy=0, done=0, Result=0, Zero=1; internal accumulators cleared.
- States:
  - IDLE: on start=1, latch MulDivOp, SrcA and SrcB plus operand signs and absolute values; clear count; go to CALC.
  - CALC: one iteration per cycle for exactly 32 cycles (count 0..31), then go to FINISH.
  - FINISH: apply sign correction and special cases; register Result and Zero; assert done for this cycle only; go to IDLE.
- Latency and throughput:
  - Fixed for every op: start sampled at edge E; done=1 in the cycle after edge E+33.
  - busy=1 after edges E through E+32; busy=0 in the done cycle.
  - A new start is accepted in the done cycle (back-to-back operation allowed).
  - start while busy=1 is ignored; operands are not re-sampled.
- Multiply:
  - Unsigned shift-add on |A| and |B| into a 64-bit product.
  - Signedness: A is signed for MUL/MULH/MULHSU; B is signed for MUL/MULH only.
  - Negate the product if the effective signs differ.
  - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
- Divide:
  - Unsigned restoring division on |A| / |B|.
  - Quotient sign = signA ^ signB; remainder sign = signA (DIV/REM only).
- Special cases, applied in FINISH and overriding the normal result:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give SrcA unchanged.
  - Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- reset=1 mid-operation aborts in the same edge; no done pulse.
- Result and Zero change only in a done cycle or on reset.
- No X propagation: every register has a defined reset value.

Decomposition:
- Package riscv_muldiv_pkg:
  - localparams for the eight MulDivOp encodings.
  - State encoding (IDLE=2'd0, CALC=2'd1, FINISH=2'd2).
  - MULDIV_ITER=32 and MULDIV_LATENCY=34.
- One module; no sub-module needed. The multiply and divide datapaths share the 64-bit accumulator and the 32-bit working register.

Test Plan:
- MUL 7 x 6: start with SrcA=7, SrcB=6 -> done exactly 34 cycles after the start edge, Result=42, Zero=0, busy high for 33 cycles.
- High-half products:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed division:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7%2 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0, Zero=1.
- Divide by zero:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV -1/0 -> 0xFFFFFFFF.
- Handshake:
  - start pulsed again at cycle 10 of an operation with different operands -> ignored; the first result is returned.
  - A new start in the done cycle -> accepted; second done 34 cycles later.
- Reset at cycle 15 of a DIV -> next cycle busy=0, done=0, Result=0, Zero=1; no done pulse; a following MUL 3x3 returns 9.
